// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage.
//   - Forwards operands from EX/MEM and MEM/WB. EX/MEM has priority.
//     Register x0 is never forwarded.
//   - Performs the single-cycle ALU operations combinationally.
//   - Runs an iterative shift-add multiplier for MUL. While it is busy,
//     Stall_o is high, the upstream stages hold and EX/MEM captures bubbles.
// Build option:
//   MUL_EARLY_TERM_EN - when defined, the multiplier stops as soon as no
//   multiplier bits remain. When undefined, it always runs 32 iterations.
//   The product is the same either way; only the latency differs.
module ex_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemStall_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        Func10_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic              EXMEM_RegWrite_i,
    input  logic [4:0]        EXMEM_RDaddr_i,
    input  logic [DATA_W-1:0] EXMEM_ALUResult_i,
    input  logic              MEMWB_RegWrite_i,
    input  logic [4:0]        MEMWB_RDaddr_i,
    input  logic [DATA_W-1:0] MEMWB_WriteData_i,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] MemWriteData_o,
    output logic              Stall_o
);

    // ALUOp encodings
    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    // R-type {funct7, funct3} encodings
    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_OR  = 10'b0000000_110;
    localparam logic [9:0] F_XOR = 10'b0000000_100;
    localparam logic [9:0] F_SLL = 10'b0000000_001;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    // I-type funct3 encodings
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;

    localparam logic [4:0] LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

    mul_state_t        state_r;
    logic [4:0]        count_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;

    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [DATA_W-1:0] mplier_next_s;
    logic [DATA_W-1:0] mcand_next_s;
    logic              is_mul_s;
    logic              stall_s;

    // Pick the newest in-flight value for one source register.
    // x0 is hard-wired to zero, so a write to x0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] idex_data,
        input logic              exmem_we,
        input logic [4:0]        exmem_rd,
        input logic [DATA_W-1:0] exmem_data,
        input logic              memwb_we,
        input logic [4:0]        memwb_rd,
        input logic [DATA_W-1:0] memwb_data
    );
        if (exmem_we && (exmem_rd == addr) && (addr != 5'd0)) begin
            return exmem_data;
        end else if (memwb_we && (memwb_rd == addr) && (addr != 5'd0)) begin
            return memwb_data;
        end else begin
            return idex_data;
        end
    endfunction

    // Operand selection: forwarding for both sources, then the immediate mux for B
    always_comb begin
        fwd_a_s = fwd_sel(RS1addr_i, RS1data_i,
                          EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_ALUResult_i,
                          MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_WriteData_i);
        fwd_b_s = fwd_sel(RS2addr_i, RS2data_i,
                          EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_ALUResult_i,
                          MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_WriteData_i);
        if (ALUSrc_i) begin
            op_b_s = Imm_i;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    assign MemWriteData_o = fwd_b_s;

    assign is_mul_s = (ALUOp_i == OP_R) && (Func10_i == F_MUL);

    // Single-cycle ALU. MUL and undefined encodings produce 0 here.
    always_comb begin
        alu_res_s = {DATA_W{1'b0}};
        case (ALUOp_i)
            OP_MEM: alu_res_s = fwd_a_s + op_b_s;
            OP_BR:  alu_res_s = fwd_a_s - op_b_s;
            OP_R: begin
                case (Func10_i)
                    F_ADD:   alu_res_s = fwd_a_s + op_b_s;
                    F_SUB:   alu_res_s = fwd_a_s - op_b_s;
                    F_AND:   alu_res_s = fwd_a_s & op_b_s;
                    F_OR:    alu_res_s = fwd_a_s | op_b_s;
                    F_XOR:   alu_res_s = fwd_a_s ^ op_b_s;
                    F_SLL:   alu_res_s = fwd_a_s << op_b_s[SHAMT_W-1:0];
                    default: alu_res_s = {DATA_W{1'b0}};
                endcase
            end
            OP_I: begin
                case (Func10_i[2:0])
                    F3_ADDI: alu_res_s = fwd_a_s + op_b_s;
                    F3_SRAI: alu_res_s = $unsigned($signed(fwd_a_s) >>> Imm_i[SHAMT_W-1:0]);
                    default: alu_res_s = {DATA_W{1'b0}};
                endcase
            end
            default: alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    // Next values of the shift-add registers for one iteration
    always_comb begin
        mcand_next_s  = {mcand_r[DATA_W-2:0], 1'b0};
        mplier_next_s = {1'b0, mplier_r[DATA_W-1:1]};
    end

    // Multiplier sequencer: latch the operands, iterate, then hold the
    // result until the pipeline is allowed to advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            count_r  <= 5'd0;
            acc_r    <= {DATA_W{1'b0}};
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_mul_s) begin
                        mcand_r  <= fwd_a_s;
                        mplier_r <= op_b_s;
                        acc_r    <= {DATA_W{1'b0}};
                        count_r  <= 5'd0;
`ifdef MUL_EARLY_TERM_EN
                        if (op_b_s == {DATA_W{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_BUSY;
                        end
`else
                        state_r  <= ST_BUSY;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mcand_r  <= mcand_next_s;
                    mplier_r <= mplier_next_s;
                    count_r  <= count_r + 5'd1;
                    if (count_r == LAST_ITER) begin
                        state_r <= ST_DONE;
`ifdef MUL_EARLY_TERM_EN
                    end else if (mplier_next_s == {DATA_W{1'b0}}) begin
                        state_r <= ST_DONE;
`endif
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Leave on the same edge at which ID/EX loads the next instruction
                    if (!MemStall_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign stall_s = ((state_r == ST_IDLE) && is_mul_s) || (state_r == ST_BUSY);
    assign Stall_o = stall_s;

    // Result mux: product in DONE, zero while the multiplier stalls, else ALU
    always_comb begin
        if (state_r == ST_DONE) begin
            ALUResult_o = acc_r;
        end else if (stall_s) begin
            ALUResult_o = {DATA_W{1'b0}};
        end else begin
            ALUResult_o = alu_res_s;
        end
    end

endmodule
